// File: rtl/ticket_print_arbiter_if.sv
// rtl/ticket_print_arbiter_if.sv - booth/printer-side bundle for the ticket print arbiter
interface ticket_print_arbiter_if #(
  parameter int NREQ    = 3,
  parameter int STOCK_W = 5
);
  logic [NREQ-1:0]    req;
  logic [3*NREQ-1:0]  dest;
  logic               restock;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    reject;
  logic               prn_start;
  logic [2:0]         prn_dest;
  logic               busy;
  logic [STOCK_W-1:0] stock;
  logic               sold_out;

  modport master (
    output req, dest, restock,
    input  gnt, done, reject, prn_start, prn_dest, busy, stock, sold_out
  );

  modport slave (
    input  req, dest, restock,
    output gnt, done, reject, prn_start, prn_dest, busy, stock, sold_out
  );
endinterface

// File: rtl/ticket_print_arbiter.sv
// rtl/ticket_print_arbiter.sv - round-robin printer arbiter with print timing and stock tracking
module ticket_print_arbiter #(
  parameter int NREQ         = 3,
  parameter int PRINT_CYCLES = 4,
  parameter int STOCK_INIT   = 15,
  parameter int STOCK_W      = 5
) (
  input logic                 clk,
  input logic                 rst,
  ticket_print_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, PRINT, DONE, REJ} state_t;

  state_t             r_state;
  logic [IW-1:0]      r_sel;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [STOCK_W-1:0] r_stock;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_done;
  logic [NREQ-1:0]    r_reject;
  logic               r_prn_start;
  logic [2:0]         r_prn_dest;
  logic               r_busy;

  int                 w_idx;
  logic               w_found;
  logic [IW-1:0]      w_pick;
  logic [2:0]         w_dest;
  logic               w_dest_ok;
  logic [NREQ-1:0]    w_pick_oh;
  logic [IW-1:0]      w_sel_inc;

  // First requesting booth at or after the round-robin pointer, wrapping.
  always_comb begin
    w_idx   = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && bus.req[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = IW'(w_idx);
      end
    end
  end

  assign w_dest    = bus.dest[int'(w_pick)*3 +: 3];
  assign w_dest_ok = (w_dest == 3'b001) || (w_dest == 3'b010) || (w_dest == 3'b100);
  assign w_pick_oh = NREQ'(1) << w_pick;
  assign w_sel_inc = (r_sel == IW'(NREQ-1)) ? '0 : r_sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_stock     <= STOCK_W'(STOCK_INIT);
      r_gnt       <= '0;
      r_done      <= '0;
      r_reject    <= '0;
      r_prn_start <= 1'b0;
      r_prn_dest  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_prn_start <= 1'b0;
      r_done      <= '0;
      r_reject    <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel  <= w_pick;
            r_busy <= 1'b1;
            if (r_stock == '0 || !w_dest_ok) begin
              r_state  <= REJ;
              r_reject <= w_pick_oh;
            end else begin
              r_state     <= PRINT;
              r_gnt       <= w_pick_oh;
              r_prn_start <= 1'b1;
              r_prn_dest  <= w_dest;
              r_cnt       <= CW'(PRINT_CYCLES-1);
              r_stock     <= r_stock - 1'b1;
            end
          end
        end
        PRINT: begin
          if (r_cnt == '0) begin
            r_state    <= DONE;
            r_done     <= r_gnt;
            r_gnt      <= '0;
            r_prn_dest <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE, REJ: begin
          r_state <= IDLE;
          r_ptr   <= w_sel_inc;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      // Restock overrides any decrement taken on the same edge.
      if (bus.restock) r_stock <= STOCK_W'(STOCK_INIT);
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.reject    = r_reject;
  assign bus.prn_start = r_prn_start;
  assign bus.prn_dest  = r_prn_dest;
  assign bus.busy      = r_busy;
  assign bus.stock     = r_stock;
  assign bus.sold_out  = (r_stock == '0);
endmodule

// File: tb/tb_ticket_print_arbiter.sv
// tb/tb_ticket_print_arbiter.sv - randomized and directed bench for ticket_print_arbiter
module tb_ticket_print_arbiter;
  localparam int NREQ = 3;
  localparam int PC   = 4;
  localparam int SI   = 15;
  localparam int SW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ticket_print_arbiter_if #(.NREQ(NREQ), .STOCK_W(SW)) bus ();

  ticket_print_arbiter #(
    .NREQ(NREQ), .PRINT_CYCLES(PC), .STOCK_INIT(SI), .STOCK_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [NREQ-1:0]   req_v = '0;
  logic [3*NREQ-1:0] dest_v = '0;
  logic              restock_v = 1'b0;
  assign bus.req     = req_v;
  assign bus.dest    = dest_v;
  assign bus.restock = restock_v;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] reject;
    logic            start;
    logic [2:0]      dest;
    logic            busy;
  } exp_t;

  exp_t q[$];
  int   m_stock = SI;
  int   m_ptr   = 0;
  bit   m_idle  = 1'b1;
  int   grants[$];
  int   done_seen = 0;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare every output against the model's timeline for this cycle.
  task automatic check_now();
    exp_t e;
    if (q.size() == 0) begin
      e = '0;
      m_idle = 1'b1;
    end else begin
      e = q.pop_front();
      m_idle = 1'b0;
    end
    chk("gnt",       32'(bus.gnt),       32'(e.gnt));
    chk("done",      32'(bus.done),      32'(e.done));
    chk("reject",    32'(bus.reject),    32'(e.reject));
    chk("prn_start", 32'(bus.prn_start), 32'(e.start));
    chk("prn_dest",  32'(bus.prn_dest),  32'(e.dest));
    chk("busy",      32'(bus.busy),      32'(e.busy));
    chk("stock",     32'(bus.stock),     32'(m_stock));
    chk("sold_out",  32'(bus.sold_out),  32'(m_stock == 0));
    if (bus.done != '0) done_seen++;
    if (bus.prn_start) begin
      for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) grants.push_back(i);
    end
    req_v = req_v & ~(e.done | e.reject);
  endtask

  // Decide what the coming edge does and lay out the resulting output timeline.
  task automatic model_edge();
    int   w;
    logic [2:0] d;
    exp_t e;
    if (m_idle && req_v != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req_v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      d = dest_v[3*w +: 3];
      if (m_stock == 0 || $countones(d) != 1) begin
        e = '0; e.reject = NREQ'(1) << w; e.busy = 1'b1;
        q.push_back(e);
      end else begin
        for (int c = 1; c <= PC; c++) begin
          e = '0; e.gnt = NREQ'(1) << w; e.start = (c == 1); e.dest = d; e.busy = 1'b1;
          q.push_back(e);
        end
        e = '0; e.done = NREQ'(1) << w; e.busy = 1'b1;
        q.push_back(e);
        m_stock = m_stock - 1;
      end
      m_ptr = (w + 1) % NREQ;
    end
    if (restock_v) m_stock = SI;
  endtask

  task automatic cyc();
    model_edge();
    @(negedge clk);
    check_now();
  endtask

  task automatic model_reset();
    q.delete();
    m_stock = SI;
    m_ptr   = 0;
    req_v   = '0;
    restock_v = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    check_now();
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!req_v[i] && $urandom_range(0, 3) == 0) begin
        req_v[i] = 1'b1;
        if ($urandom_range(0, 4) != 0) dest_v[3*i +: 3] = 3'(1 << $urandom_range(0, 2));
        else dest_v[3*i +: 3] = 3'($urandom_range(0, 7));
      end
    end
    restock_v = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);
    chk("reset stock", 32'(bus.stock), 32'd15);
    chk("reset sold_out", 32'(bus.sold_out), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset outs", 32'({bus.gnt, bus.done, bus.reject}), 32'd0);

    // Single booth print.
    req_v = 3'b001; dest_v = 9'b000_000_001;
    cyc();
    chk("single gnt c1", 32'(bus.gnt), 32'd1);
    chk("single start c1", 32'(bus.prn_start), 32'd1);
    chk("single stock c1", 32'(bus.stock), 32'd14);
    for (int c = 2; c <= PC; c++) begin
      cyc();
      chk("single prn_dest", 32'(bus.prn_dest), 32'd1);
    end
    cyc();
    chk("single done", 32'(bus.done), 32'd1);
    cyc();
    chk("single idle", 32'(bus.busy), 32'd0);

    // Round-robin from a fresh pointer.
    do_reset(2);
    grants.delete();
    req_v = 3'b111; dest_v = 9'b100_010_001;
    repeat (3*(PC+2)) cyc();
    chk("rr count", 32'(grants.size()), 32'd3);
    for (int i = 0; i < 3 && i < grants.size(); i++) chk("rr order", 32'(grants[i]), 32'(i));
    req_v = 3'b101;
    cyc();
    chk("rr wrap gnt", 32'(bus.gnt), 32'b001);
    repeat (PC+1) cyc();
    req_v = '0;

    // Malformed destination.
    req_v = 3'b010; dest_v = 9'b100_011_001;
    cyc();
    chk("bad dest reject", 32'(bus.reject), 32'b010);
    chk("bad dest start", 32'(bus.prn_start), 32'd0);
    chk("bad dest stock", 32'(bus.stock), 32'd11);
    cyc();
    req_v = 3'b111; dest_v = 9'b100_010_001;
    cyc();
    chk("ptr after reject", 32'(bus.gnt), 32'b100);
    repeat (PC+1) cyc();
    req_v = '0;

    // Restock on the accepting edge.
    req_v = 3'b001; restock_v = 1'b1;
    cyc();
    restock_v = 1'b0;
    chk("restock collide stock", 32'(bus.stock), 32'd15);
    chk("restock collide gnt", 32'(bus.gnt), 32'b001);
    repeat (PC+1) cyc();

    // Reset while printing.
    req_v = 3'b010;
    cyc();
    cyc();
    chk("midprint stock", 32'(bus.stock), 32'd14);
    rst = 1'b1;
    #1;
    chk("midprint gnt", 32'(bus.gnt), 32'd0);
    chk("midprint busy", 32'(bus.busy), 32'd0);
    chk("midprint stock rst", 32'(bus.stock), 32'd15);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    check_now();
    repeat (PC+2) cyc();
    chk("midprint no done", 32'(done_seen), 32'd0);

    // Drain stock to zero, then refuse, then restock.
    for (int n = 0; n < SI; n++) begin
      req_v = 3'b001; dest_v = 9'b000_000_001;
      repeat (PC+2) cyc();
    end
    chk("drained stock", 32'(bus.stock), 32'd0);
    chk("drained sold_out", 32'(bus.sold_out), 32'd1);
    req_v = 3'b001;
    cyc();
    chk("sold out reject", 32'(bus.reject), 32'b001);
    cyc();
    restock_v = 1'b1;
    cyc();
    restock_v = 1'b0;
    chk("restock stock", 32'(bus.stock), 32'd15);
    chk("restock sold_out", 32'(bus.sold_out), 32'd0);

    // Randomized traffic against the model.
    repeat (3000) begin
      rand_inputs();
      cyc();
    end
    restock_v = 1'b0;
    for (int n = 0; n < 4*(PC+2); n++) begin
      req_v = req_v & {NREQ{bus.busy}};
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
